// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
// Arbitrates NUM_REQ command requesters onto a single AXI4-Lite master
// command port, one transaction in flight at a time.
//
// Build option:
//   AXI_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin (default)
//
// Flow: IDLE accepts a winner (req_ready pulse), ISSUE pulses m_start,
// WAIT holds until m_done, then req_done pulses for the granted requester.
module axi_lite_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [31:0]             req_rdata,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id,
    output logic                    m_start,
    output logic                    m_write_en,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    input  logic [31:0]             m_rdata,
    input  logic                    m_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic                 wr_q, wr_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    // Arbiter result for the current cycle
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic                 accept;

    // Per-requester views of the flattened address/data buses
    logic [31:0]          addr_arr  [NUM_REQ];
    logic [31:0]          wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[32*i +: 32];
        assign wdata_arr[i] = req_wdata[32*i +: 32];
    end

    // A grant only happens from IDLE; held low while rst is asserted so that
    // req_ready is cleared asynchronously along with the state.
    assign accept = (state_q == IDLE) && win_found && !rst;

`ifdef AXI_ARB_FIXED_PRIO_EN

    // Fixed priority: the lowest-numbered valid requester wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[IDW'(k)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(k);
            end
        end
    end

`else

    logic [IDW-1:0] ptr_q, ptr_d;
    int             cand_i;

    // Round-robin: search starts at ptr_q and wraps past NUM_REQ-1 to 0
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_i    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            if (!win_found && req_valid[IDW'(cand_i)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand_i);
            end
        end
    end

    // Pointer moves to the slot after the winner on every acceptance
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (win_idx == IDW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

    // Next-state and command capture; req_ready is a combinational grant
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = '0;
        req_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready[win_idx] = 1'b1;
                    grant_id_d         = win_idx;
                    wr_d               = req_write[win_idx];
                    addr_d             = addr_arr[win_idx];
                    wdata_d            = wdata_arr[win_idx];
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                // m_done here is not a completion of this command
                state_d = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    // Read data is captured for writes too
                    rdata_d              = m_rdata;
                    done_d[grant_id_q]   = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign m_start    = (state_q == ISSUE);
    assign m_write_en = wr_q;
    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign grant_id   = grant_id_q;
    assign req_rdata  = rdata_q;
    assign req_done   = done_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed bench for axi_lite_cmd_arbiter (NUM_REQ=4).
// Inputs change and outputs are sampled 1ns after the falling clock edge.
module tb_axi_lite_cmd_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [32*N-1:0] req_addr  = '0;
    logic [32*N-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done;
    logic [31:0]     req_rdata;
    logic            busy;
    logic [1:0]      grant_id;
    logic            m_start;
    logic            m_write_en;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [31:0]     m_rdata = '0;
    logic            m_done  = 1'b0;

    int total = 0;
    int bad   = 0;

    axi_lite_cmd_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_done(req_done), .req_rdata(req_rdata),
        .busy(busy), .grant_id(grant_id),
        .m_start(m_start), .m_write_en(m_write_en),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic set_req(input int id, input bit wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[id]         = 1'b1;
        req_write[id]         = wr;
        req_addr[32*id +: 32]  = a;
        req_wdata[32*id +: 32] = d;
    endtask

    // Fixed-timing single transaction from IDLE (drive only)
    task automatic run_txn(input int id, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd);
        @(negedge clk); set_req(id, wr, a, d);
        @(negedge clk); req_valid = '0;
        @(negedge clk); m_done = 1'b1; m_rdata = rd;
        @(negedge clk); m_done = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || m_start !== 1'b0) begin bad++; $display("FAIL rst_ctrl busy=%b m_start=%b exp 0 0", busy, m_start); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready act=%b exp=0000", req_ready); end
        total++; if (req_done !== 4'b0000 || grant_id !== 2'd0) begin bad++; $display("FAIL rst_done_gid done=%b gid=%0d exp 0000 0", req_done, grant_id); end
        total++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_write_en !== 1'b0) begin bad++; $display("FAIL rst_mcmd addr=%h wdata=%h we=%b exp 0", m_addr, m_wdata, m_write_en); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata act=%h exp=0", req_rdata); end
        @(negedge clk); req_valid = '0; rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk); set_req(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF); #1;
        total++; if (req_ready !== 4'b0100 || busy !== 1'b0) begin bad++; $display("FAIL wr_ready ready=%b busy=%b exp 0100 0", req_ready, busy); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (m_start !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL wr_issue start=%b busy=%b gid=%0d exp 1 1 2", m_start, busy, grant_id); end
        total++; if (m_addr !== 32'h10 || m_wdata !== 32'hDEADBEEF || m_write_en !== 1'b1) begin bad++; $display("FAIL wr_cmd addr=%h wdata=%h we=%b", m_addr, m_wdata, m_write_en); end
        @(negedge clk); #1;
        total++; if (m_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wr_wait start=%b busy=%b exp 0 1", m_start, busy); end
        @(negedge clk); #1;
        total++; if (m_addr !== 32'h10 || m_wdata !== 32'hDEADBEEF || req_done !== 4'b0000) begin bad++; $display("FAIL wr_hold addr=%h wdata=%h done=%b", m_addr, m_wdata, req_done); end
        m_done = 1'b1; m_rdata = 32'hAAAA_5555;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== 4'b0100 || busy !== 1'b0) begin bad++; $display("FAIL wr_done done=%b busy=%b exp 0100 0", req_done, busy); end
        total++; if (req_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL wr_rdata act=%h exp=aaaa5555", req_rdata); end
        @(negedge clk); #1;
        total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL wr_done_pulse act=%b exp=0000", req_done); end
    endtask

    task automatic test_single_read();
        @(negedge clk); set_req(1, 1'b0, 32'h0000_0024, 32'h0); #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rd_ready act=%b exp=0010", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (m_start !== 1'b1 || m_addr !== 32'h24 || m_write_en !== 1'b0 || grant_id !== 2'd1) begin bad++; $display("FAIL rd_issue start=%b addr=%h we=%b gid=%0d", m_start, m_addr, m_write_en, grant_id); end
        @(negedge clk); m_done = 1'b1; m_rdata = 32'h1234_5678;
        @(negedge clk); m_done = 1'b0; m_rdata = 32'hFFFF_0000; #1;
        total++; if (req_done !== 4'b0010 || req_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_done done=%b rdata=%h exp 0010 12345678", req_done, req_rdata); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (req_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_hold act=%h exp=12345678", req_rdata); end
    endtask

    task automatic test_ignore_mdone();
        @(negedge clk); m_done = 1'b1; m_rdata = 32'h0000_0BAD;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (busy !== 1'b0 || req_done !== 4'b0000 || req_rdata !== 32'h12345678) begin bad++; $display("FAIL idle_mdone busy=%b done=%b rdata=%h", busy, req_done, req_rdata); end
        @(negedge clk); set_req(0, 1'b1, 32'h0000_0080, 32'h0000_00A5);
        @(negedge clk); req_valid = '0; m_done = 1'b1; #1;
        total++; if (m_start !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL ign_issue start=%b gid=%0d exp 1 0", m_start, grant_id); end
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (busy !== 1'b1 || req_done !== 4'b0000) begin bad++; $display("FAIL issue_mdone busy=%b done=%b exp 1 0000", busy, req_done); end
        @(negedge clk); m_done = 1'b1; m_rdata = 32'h0000_0055;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== 4'b0001 || req_rdata !== 32'h55) begin bad++; $display("FAIL ign_done done=%b rdata=%h exp 0001 55", req_done, req_rdata); end
    endtask

    task automatic test_contention();
        int           exp_id;
        int           n;
        logic [N-1:0] exp_oh;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req_valid = '1; #1;
        for (int g = 0; g < 5; g++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % N;
`endif
            exp_oh = '0;
            exp_oh[exp_id] = 1'b1;
            n = 0;
            while (req_ready === 4'b0000 && n < 8) begin
                @(negedge clk); #1; n++;
            end
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d act=%b exp=%b", g, req_ready, exp_oh); end
            @(negedge clk); #1;
            total++; if (m_start !== 1'b1 || grant_id !== 2'(exp_id)) begin bad++; $display("FAIL rr_issue%0d start=%b gid=%0d exp 1 %0d", g, m_start, grant_id, exp_id); end
            @(negedge clk); m_done = 1'b1;
            @(negedge clk); m_done = 1'b0; #1;
            total++; if (req_done !== exp_oh) begin bad++; $display("FAIL rr_done%0d act=%b exp=%b", g, req_done, exp_oh); end
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        int           first;
        int           second;
        logic [N-1:0] oh1;
        logic [N-1:0] oh2;
`ifdef AXI_ARB_FIXED_PRIO_EN
        first = 0; second = 3;
`else
        first = 3; second = 0;
`endif
        oh1 = '0; oh1[first]  = 1'b1;
        oh2 = '0; oh2[second] = 1'b1;
        run_txn(2, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        @(negedge clk); req_valid = 4'b1001; #1;
        total++; if (req_ready !== oh1) begin bad++; $display("FAIL wrap_first act=%b exp=%b", req_ready, oh1); end
        @(negedge clk); req_valid[first] = 1'b0; #1;
        total++; if (m_start !== 1'b1 || grant_id !== 2'(first)) begin bad++; $display("FAIL wrap_gid1 start=%b gid=%0d exp 1 %0d", m_start, grant_id, first); end
        @(negedge clk); m_done = 1'b1;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== oh1 || req_ready !== oh2) begin bad++; $display("FAIL wrap_second done=%b ready=%b exp %b %b", req_done, req_ready, oh1, oh2); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (m_start !== 1'b1 || grant_id !== 2'(second)) begin bad++; $display("FAIL wrap_gid2 start=%b gid=%0d exp 1 %0d", m_start, grant_id, second); end
        @(negedge clk); m_done = 1'b1;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== oh2) begin bad++; $display("FAIL wrap_done2 act=%b exp=%b", req_done, oh2); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); set_req(1, 1'b1, 32'h0000_0040, 32'h0000_7777);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        total++; if (busy !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL rmw_pre busy=%b gid=%0d exp 1 1", busy, grant_id); end
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0 || m_start !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rmw_async busy=%b start=%b gid=%0d exp 0 0 0", busy, m_start, grant_id); end
        total++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_write_en !== 1'b0) begin bad++; $display("FAIL rmw_mcmd addr=%h wdata=%h we=%b exp 0", m_addr, m_wdata, m_write_en); end
        @(negedge clk); #1;
        total++; if (req_done !== 4'b0000 || req_rdata !== 32'h0) begin bad++; $display("FAIL rmw_nodone done=%b rdata=%h exp 0000 0", req_done, req_rdata); end
        rst = 1'b0; m_done = 1'b1; m_rdata = 32'hCAFE_0001;
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== 4'b0000 || busy !== 1'b0 || req_rdata !== 32'h0) begin bad++; $display("FAIL rmw_spurious done=%b busy=%b rdata=%h", req_done, busy, req_rdata); end
        req_valid = 4'b1001; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmw_regrant act=%b exp=0001", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (m_start !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL rmw_issue start=%b gid=%0d exp 1 0", m_start, grant_id); end
        @(negedge clk); m_done = 1'b1;
        @(negedge clk); m_done = 1'b0;
    endtask

    task automatic test_forfeit();
        @(negedge clk); set_req(0, 1'b0, 32'h0000_0200, 32'h0);
        @(negedge clk); req_valid = 4'b0010; #1;
        total++; if (req_ready !== 4'b0000 || m_start !== 1'b1) begin bad++; $display("FAIL ff_issue ready=%b start=%b exp 0000 1", req_ready, m_start); end
        @(negedge clk); req_valid = '0; m_done = 1'b1; #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ff_wait ready=%b exp 0000", req_ready); end
        @(negedge clk); m_done = 1'b0; #1;
        total++; if (req_done !== 4'b0001) begin bad++; $display("FAIL ff_done act=%b exp=0001", req_done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++; if (m_start !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL ff_idle%0d start=%b busy=%b ready=%b", c, m_start, busy, req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_ignore_mdone();
        test_contention();
        test_wrap();
        test_reset_mid_wait();
        test_forfeit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
